// File: rtl/refresh_scheduler.sv
// Per-scanline DRAM refresh window generator with CPU-bus arbitration against DMA.
// Optional debug build (refresh_inhibit input, refresh_cnt output): define REFRESH_SCHED_DEBUG_EN.
module refresh_scheduler #(
  parameter int LINE_LEN    = 1364,
  parameter int REFRESH_POS = 538,
  parameter int REFRESH_LEN = 40,
  parameter int HW          = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic          cpu_en,
  input  logic          dma_req,
`ifdef REFRESH_SCHED_DEBUG_EN
  input  logic          refresh_inhibit,
  output logic [15:0]   refresh_cnt,
`endif
  output logic          dma_grant,
  output logic          refresh,
  output logic          cpu_stall,
  output logic [HW-1:0] hpos
);

  localparam int LW = $clog2(REFRESH_LEN + 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_REFRESH = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [LW-1:0]   len_cnt_r, len_cnt_s;
  logic [HW-1:0]   hpos_r, hpos_s;
  logic            pending_r, pending_s;
  logic            grant_r, grant_s;
  logic            inhibit_s;
  logic            set_pending_s;
  logic            start_s;

`ifdef REFRESH_SCHED_DEBUG_EN
  logic [15:0]     refresh_cnt_r;
  assign inhibit_s   = refresh_inhibit;
  assign refresh_cnt = refresh_cnt_r;
`else
  assign inhibit_s   = 1'b0;
`endif

  // Next-state logic for line position, pending request, refresh FSM and DMA grant.
  always_comb begin
    state_s       = state_r;
    len_cnt_s     = len_cnt_r;
    hpos_s        = hpos_r;
    pending_s     = pending_r;
    grant_s       = grant_r;
    set_pending_s = (hpos_r == HW'(REFRESH_POS)) && !line_start && !inhibit_s;
    start_s       = (state_r == ST_IDLE) && pending_r && cpu_en;

    if (line_start) begin
      hpos_s = {HW{1'b0}};
    end else if (hpos_r == HW'(LINE_LEN - 1)) begin
      hpos_s = {HW{1'b0}};
    end else begin
      hpos_s = hpos_r + HW'(1);
    end

    // A new request on the same edge as a refresh start is kept for the next window.
    if (set_pending_s) begin
      pending_s = 1'b1;
    end else if (start_s) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s   = ST_REFRESH;
          len_cnt_s = LW'(1);
        end else begin
          state_s   = ST_IDLE;
          len_cnt_s = {LW{1'b0}};
        end
      end
      ST_REFRESH: begin
        if (len_cnt_r == LW'(REFRESH_LEN)) begin
          state_s   = ST_IDLE;
          len_cnt_s = {LW{1'b0}};
        end else begin
          state_s   = ST_REFRESH;
          len_cnt_s = len_cnt_r + LW'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        len_cnt_s = {LW{1'b0}};
      end
    endcase

    // Refresh start preempts the grant; otherwise the grant only moves on CPU boundaries.
    if (start_s) begin
      grant_s = 1'b0;
    end else if (cpu_en) begin
      if (!dma_req) begin
        grant_s = 1'b0;
      end else if (!pending_r && (state_r == ST_IDLE) && !grant_r) begin
        grant_s = 1'b1;
      end else begin
        grant_s = grant_r;
      end
    end else begin
      grant_s = grant_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      len_cnt_r <= {LW{1'b0}};
      hpos_r    <= {HW{1'b0}};
      pending_r <= 1'b0;
      grant_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      len_cnt_r <= len_cnt_s;
      hpos_r    <= hpos_s;
      pending_r <= pending_s;
      grant_r   <= grant_s;
    end
  end

`ifdef REFRESH_SCHED_DEBUG_EN
  // Saturating count of refresh windows started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_r <= 16'h0000;
    end else if (start_s && (refresh_cnt_r != 16'hFFFF)) begin
      refresh_cnt_r <= refresh_cnt_r + 16'h0001;
    end else begin
      refresh_cnt_r <= refresh_cnt_r;
    end
  end
`endif

  assign refresh   = (state_r == ST_REFRESH);
  assign dma_grant = grant_r;
  assign cpu_stall = refresh | dma_grant;
  assign hpos      = hpos_r;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed, table-driven bench for refresh_scheduler; checkpoints are keyed by phase and hpos.
module tb_refresh_scheduler;

  localparam int LINE_LEN = 1364;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic        cpu_en;
  logic        dma_req;
  logic        dma_grant;
  logic        refresh;
  logic        cpu_stall;
  logic [10:0] hpos;
`ifdef REFRESH_SCHED_DEBUG_EN
  logic        refresh_inhibit;
  logic [15:0] refresh_cnt;
  int          cnt_saved;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int tb_h  = 0;

  typedef struct {
    int phase;
    int h;
    bit ref_e;
    bit gnt_e;
  } chk_t;

  chk_t tbl[$];
  bit   hit[64];

  refresh_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .cpu_en     (cpu_en),
    .dma_req    (dma_req),
`ifdef REFRESH_SCHED_DEBUG_EN
    .refresh_inhibit (refresh_inhibit),
    .refresh_cnt     (refresh_cnt),
`endif
    .dma_grant  (dma_grant),
    .refresh    (refresh),
    .cpu_stall  (cpu_stall),
    .hpos       (hpos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int p, input int h, input bit r, input bit g);
    chk_t c;
    c.phase = p; c.h = h; c.ref_e = r; c.gnt_e = g;
    tbl.push_back(c);
  endfunction

  task automatic run_phase(input int ph, input int n);
    for (int c = 0; c < n; c++) begin
      int h;
      h          = tb_h;
      cpu_en     = (h % 6 == 0) && !(ph == 5 && h >= 530 && h < 600);
      dma_req    = (ph == 2 && h >= 100 && h < 1300) || (ph == 5 && h >= 545 && h < 1300);
      line_start = (ph == 3 && h == 538);
`ifdef REFRESH_SCHED_DEBUG_EN
      refresh_inhibit = (ph == 8);
`endif
      @(posedge clk);
      #1;
      tb_h = line_start ? 0 : ((h == LINE_LEN - 1) ? 0 : h + 1);
      check($sformatf("hpos p%0d", ph), {21'd0, hpos}, tb_h);
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].phase == ph && tbl[i].h == tb_h) begin
          hit[i] = 1'b1;
          check($sformatf("refresh p%0d h%0d", ph, tb_h), {31'd0, refresh}, {31'd0, tbl[i].ref_e});
          check($sformatf("dma_grant p%0d h%0d", ph, tb_h), {31'd0, dma_grant}, {31'd0, tbl[i].gnt_e});
          check($sformatf("cpu_stall p%0d h%0d", ph, tb_h), {31'd0, cpu_stall},
                {31'd0, tbl[i].ref_e | tbl[i].gnt_e});
        end
      end
    end
  endtask

  initial begin
    // phase 1: basic refresh window
    add(1, 539, 1'b0, 1'b0); add(1, 540, 1'b0, 1'b0); add(1, 541, 1'b1, 1'b0);
    add(1, 560, 1'b1, 1'b0); add(1, 580, 1'b1, 1'b0); add(1, 581, 1'b0, 1'b0);
    // phase 2: DMA grant, preemption, regrant, release
    add(2, 102, 1'b0, 1'b0); add(2, 103, 1'b0, 1'b1); add(2, 539, 1'b0, 1'b1);
    add(2, 541, 1'b1, 1'b0); add(2, 580, 1'b1, 1'b0); add(2, 581, 1'b0, 1'b0);
    add(2, 582, 1'b0, 1'b0); add(2, 583, 1'b0, 1'b1); add(2, 1302, 1'b0, 1'b1);
    add(2, 1303, 1'b0, 1'b0);
    // phases 3/4: line_start coincident with REFRESH_POS
    add(3, 537, 1'b0, 1'b0); add(3, 0, 1'b0, 1'b0);
    add(4, 5, 1'b0, 1'b0); add(4, 540, 1'b0, 1'b0); add(4, 541, 1'b1, 1'b0);
    add(4, 581, 1'b0, 1'b0);
    // phase 5: cpu_en withheld while pending, DMA waits
    add(5, 539, 1'b0, 1'b0); add(5, 600, 1'b0, 1'b0); add(5, 601, 1'b1, 1'b0);
    add(5, 640, 1'b1, 1'b0); add(5, 641, 1'b0, 1'b0); add(5, 642, 1'b0, 1'b0);
    add(5, 643, 1'b0, 1'b1); add(5, 1303, 1'b0, 1'b0);
    // phases 6/7: reset mid-refresh, then recovery
    add(6, 541, 1'b1, 1'b0); add(6, 560, 1'b1, 1'b0);
    add(7, 541, 1'b1, 1'b0); add(7, 581, 1'b0, 1'b0);
`ifdef REFRESH_SCHED_DEBUG_EN
    add(8, 541, 1'b0, 1'b0);
`endif

    reset = 1'b1; line_start = 1'b0; cpu_en = 1'b0; dma_req = 1'b0;
`ifdef REFRESH_SCHED_DEBUG_EN
    refresh_inhibit = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset hpos", {21'd0, hpos}, 32'd0);
    check("reset refresh", {31'd0, refresh}, 32'd0);
    check("reset dma_grant", {31'd0, dma_grant}, 32'd0);
    check("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
    reset = 1'b0;
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    tb_h = 0;
    check("line_start hpos", {21'd0, hpos}, 32'd0);

    run_phase(1, LINE_LEN);
    run_phase(2, LINE_LEN);
    run_phase(3, 539);
    run_phase(4, LINE_LEN);
    run_phase(5, LINE_LEN);
    run_phase(6, 560);

    reset = 1'b1;
    #2;
    check("async reset refresh", {31'd0, refresh}, 32'd0);
    check("async reset dma_grant", {31'd0, dma_grant}, 32'd0);
    check("async reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("async reset hpos", {21'd0, hpos}, 32'd0);
    #1;
    reset = 1'b0;
    tb_h = 0;
    run_phase(7, LINE_LEN);

`ifdef REFRESH_SCHED_DEBUG_EN
    cnt_saved = int'(refresh_cnt);
    run_phase(8, LINE_LEN);
    check("refresh_cnt inhibited", {16'd0, refresh_cnt}, cnt_saved);
    run_phase(9, 3 * LINE_LEN);
    check("refresh_cnt three lines", {16'd0, refresh_cnt}, cnt_saved + 3);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      if (!hit[i]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL checkpoint p%0d h%0d: got not reached expected reached", tbl[i].phase, tbl[i].h);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/refresh_scheduler.md
Name: refresh_scheduler

Overview:
- Generates the once-per-scanline DRAM refresh window in the console.
- Arbitrates the CPU bus between that refresh window and general-purpose DMA.
- Counts master clocks within a line and raises a refresh request at a fixed horizontal position; refresh starts on a CPU cycle boundary and holds `refresh` for a fixed length.
- DMA is granted only outside refresh; refresh preempts an active DMA grant, and the grant resumes afterwards.

Parameters:
- LINE_LEN, 1364: master clocks per scanline; `hpos` wraps at LINE_LEN-1.
- REFRESH_POS, 538: `hpos` value at which the per-line refresh request is latched.
- REFRESH_LEN, 40: cycles for which `refresh` is held high per refresh.
- HW, 11: width of the `hpos` counter; must satisfy 2^HW >= LINE_LEN.

Ports:
- clk  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-clk pulse at scanline start; resynchronises `hpos`.
- cpu_en  in  1  CPU cycle-boundary enable.
- dma_req  in  1  DMA engine requests the bus (level).
- dma_grant  out  1  DMA owns the bus.
- refresh  out  1  refresh window active.
- cpu_stall  out  1  equals refresh | dma_grant.
- hpos  out  HW  current master-clock position in the line.

Behaviour:
- Reset (async): hpos=0, pending=0, state=IDLE, len counter=0, dma_grant=0, refresh=0, cpu_stall=0.
- hpos:
  - line_start → 0 on next edge.
  - Otherwise hpos==LINE_LEN-1 → 0.
  - Otherwise hpos+1.
- pending:
  - Set on the edge where hpos==REFRESH_POS and line_start=0.
  - line_start coincident with hpos==REFRESH_POS → no set for that line.
  - Cleared on the edge that enters REFRESH.
  - A set while already in REFRESH is kept and serviced after the current refresh.
- States: IDLE, REFRESH.
  - IDLE → REFRESH when pending & cpu_en; len counter=1.
  - In REFRESH: len counter increments each clk.
  - When len counter==REFRESH_LEN: → IDLE, counter=0.
  - refresh = (state==REFRESH). It is high exactly REFRESH_LEN clks; first high cycle is the clk after the starting cpu_en edge.
- dma_grant (changes only on cpu_en edges, except forced clear):
  - Set when dma_req & ~pending & state==IDLE & ~grant.
  - Cleared when ~dma_req.
  - Cleared on the same edge that enters REFRESH (preemption). The start edge has pending=1, so refresh wins over a simultaneous grant set.
  - Never high while refresh=1.
  - After refresh ends, regranted on the first cpu_en in IDLE with dma_req=1 and pending=0.
- cpu_stall is combinational from registered refresh and dma_grant; no extra latency.
- cpu_en never high with pending=1 → refresh never starts; pending stays 1 (no timeout).
- reset during REFRESH or DMA: all outputs drop immediately (async).
- Only one pending bit exists; a second request before service does not queue twice.

Optional Feature:
- Macro: `REFRESH_SCHED_DEBUG_EN`.
- Defined:
  - Adds input `refresh_inhibit` (1 bit). While high, pending is not set.
  - Adds output `refresh_cnt` (16 bits, reset 0). Increments on each IDLE → REFRESH transition and saturates at 0xFFFF.
- Undefined: ports absent; refresh never inhibited.

Test Plan:
- Reset, line_start at t0, cpu_en every 6 clks → pending set at hpos=538; refresh rises the clk after the next cpu_en edge, stays high 40 clks, then falls; cpu_stall mirrors it.
- dma_req=1 from hpos=100 → dma_grant rises at first cpu_en; at refresh start edge grant=0, refresh=1; after 40 clks grant returns at first cpu_en; never both high.
- line_start pulsed at hpos=538 → hpos=0 next clk; no refresh that line; refresh occurs at the next 538.
- cpu_en held low from hpos=530 to 600 → refresh rises the clk after the cpu_en at 600; dma_req asserted meanwhile is not granted while pending=1.
- Async reset asserted mid-refresh (len counter=20) → refresh, dma_grant, cpu_stall, hpos all 0 without a clock edge; normal operation resumes after release.
- With `REFRESH_SCHED_DEBUG_EN`: refresh_inhibit=1 for one line → no refresh, refresh_cnt unchanged; 3 normal lines → refresh_cnt=3.
